// File: rtl/dcache_coherent.sv
// dcache_coherent: blocking N-way set-associative L1 data cache, write-through,
// read-allocate, with peer-core snoop invalidation, invalid-way-first
// replacement and line-granular LR/SC reservation tracking.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_cache_en                 0 = every access bypasses the arrays
//   i_req_*, o_req_ready       LSU request (accepted on valid & ready)
//   o_rsp_valid, o_rsp_data    load/LR data or SC status (0 ok, 1 fail)
//   o_mem_req_*, i_mem_req_ack arbiter request, held until ack
//   i_mem_rsp_valid/_data      read words returned in ascending order
//   i_snoop_valid/_addr        invalidate request from the peer core
//   o_snoop_hit                registered: last snoop invalidated a way
//   i_clear_reservation        exception-driven reservation clear
//
// state      | meaning
// S_IDLE     | ready for a request, the only state with o_req_ready = 1
// S_LOOKUP   | tag compare, choose hit / fill / write-through / SC outcome
// S_MISS_REQ | line fill (or bypass word) read request waiting for ack
// S_FILL     | collecting returned words into the latched way
// S_WR_REQ   | store / SC write request waiting for ack
// S_RESP     | one-cycle response pulse
module dcache_coherent #(
  parameter int WAYS      = 2,
  parameter int SETS      = 64,
  parameter int LINE_W    = 4,
  parameter int USE_SNOOP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cache_en,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_load,
  input  logic        i_req_store,
  input  logic        i_req_lr,
  input  logic        i_req_sc,
  input  logic [3:0]  i_req_be,
  input  logic [31:0] i_req_wdata,
  input  logic        i_clear_reservation,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ack,
  output logic [31:0] o_mem_req_addr,
  output logic        o_mem_req_rnw,
  output logic [4:0]  o_mem_req_size,
  output logic [3:0]  o_mem_req_be,
  output logic [31:0] o_mem_req_data,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  input  logic        i_snoop_valid,
  input  logic [31:0] i_snoop_addr,
  output logic        o_snoop_hit
);
  localparam int OFF_W = $clog2(LINE_W);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int LA_W  = 30 - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_FILL, S_WR_REQ, S_RESP} state_t;
  state_t r_state, w_next;

  logic [TAG_W-1:0] r_tag_mem  [WAYS][SETS];
  logic [31:0]      r_data_mem [WAYS][SETS*LINE_W];
  logic [SETS-1:0]  r_valid    [WAYS];
  logic [TAG_W-1:0] r_tag_rd   [WAYS];
  logic [31:0]      r_data_rd  [WAYS];

  logic [29:0]      r_waddr;
  logic             r_load, r_store, r_lr, r_sc;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [OFF_W-1:0] r_cnt;
  logic             r_bypass, r_fill_killed;
  logic [WAY_W-1:0] r_fill_way;
  logic [WAYS-1:0]  r_repl;
  logic             r_resv_valid;
  logic [LA_W-1:0]  r_resv_line;
  logic [31:0]      r_rsp_data;
  logic             r_snoop_hit;
  logic [31:0]      r_mem_addr, r_mem_data;
  logic             r_mem_rnw;
  logic [4:0]       r_mem_size;
  logic [3:0]       r_mem_be;

  logic [IDX_W-1:0] w_idx, w_acc_idx, w_sn_idx;
  logic [OFF_W-1:0] w_word, w_acc_word;
  logic [TAG_W-1:0] w_tag, w_sn_tag;
  logic [LA_W-1:0]  w_line, w_sn_line;
  logic [WAYS-1:0]  w_hit_vec, w_inv_vec, w_sn_vec;
  logic [31:0]      w_hit_data;
  logic [WAY_W-1:0] w_victim;
  logic             w_accept, w_hit, w_sc_ok, w_sn_v, w_sn_fill, w_sn_lr, w_resv_clr;
  logic             w_wr_hit, w_fill_wr, w_fill_last;
  logic             w_unused;

  assign w_idx      = r_waddr[OFF_W +: IDX_W];
  assign w_word     = r_waddr[OFF_W-1:0];
  assign w_tag      = r_waddr[29 -: TAG_W];
  assign w_line     = r_waddr[29 -: LA_W];
  assign w_acc_idx  = i_req_addr[OFF_W+2 +: IDX_W];
  assign w_acc_word = i_req_addr[2 +: OFF_W];
  assign w_sn_idx   = i_snoop_addr[OFF_W+2 +: IDX_W];
  assign w_sn_tag   = i_snoop_addr[31 -: TAG_W];
  assign w_sn_line  = i_snoop_addr[31 -: LA_W];
  assign w_unused   = ^{i_req_addr[1:0], i_snoop_addr[OFF_W+1:0]};

  assign w_accept    = i_req_valid && (r_state == S_IDLE);
  assign w_sn_v      = (USE_SNOOP != 0) && i_snoop_valid;
  assign w_sn_fill   = w_sn_v && (w_sn_line == w_line) &&
                       (r_state == S_LOOKUP || r_state == S_MISS_REQ || r_state == S_FILL);
  assign w_sn_lr     = w_sn_v && (w_sn_line == w_line);
  assign w_resv_clr  = i_clear_reservation || (w_sn_v && (w_sn_line == r_resv_line));
  assign w_sc_ok     = r_resv_valid && (r_resv_line == w_line);
  assign w_hit       = i_cache_en && (|w_hit_vec);
  assign w_wr_hit    = (r_state == S_LOOKUP) && w_hit && (r_sc ? w_sc_ok : r_store);
  assign w_fill_wr   = (r_state == S_FILL) && i_mem_rsp_valid && !r_bypass;
  assign w_fill_last = w_fill_wr && (r_cnt == OFF_W'(LINE_W-1));

  always_comb begin
    w_hit_vec  = '0;
    w_inv_vec  = '0;
    w_sn_vec   = '0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w][w_idx] && (r_tag_rd[w] == w_tag);
      w_inv_vec[w] = !r_valid[w][w_idx];
      w_sn_vec[w]  = w_sn_v && r_valid[w][w_sn_idx] && (r_tag_mem[w][w_sn_idx] == w_sn_tag);
      w_hit_data   = w_hit_data | (r_data_rd[w] & {32{w_hit_vec[w]}});
    end
  end

  // Lowest invalid way wins; the rotator only decides when the set is full.
  always_comb begin
    w_victim = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (r_repl[w]) w_victim = WAY_W'(w);
    if (|w_inv_vec)
      for (int w = WAYS-1; w >= 0; w--)
        if (w_inv_vec[w]) w_victim = WAY_W'(w);
  end

  // Tag/data arrays: synchronous read in the accept cycle, no reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (w_accept) begin
        r_tag_rd[w]  <= r_tag_mem[w][w_acc_idx];
        r_data_rd[w] <= r_data_mem[w][{w_acc_idx, w_acc_word}];
      end
      if (w_wr_hit && w_hit_vec[w])
        for (int b = 0; b < 4; b++)
          if (r_be[b]) r_data_mem[w][{w_idx, w_word}][8*b +: 8] <= r_wdata[8*b +: 8];
      if (w_fill_wr && (r_fill_way == WAY_W'(w))) begin
        r_data_mem[w][{w_idx, r_cnt}] <= i_mem_rsp_data;
        if (w_fill_last) r_tag_mem[w][w_idx] <= w_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_req_valid) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (r_sc)                  w_next = w_sc_ok ? S_WR_REQ : S_RESP;
        else if (r_store)          w_next = S_WR_REQ;
        else if (r_load || r_lr)   w_next = w_hit ? S_RESP : S_MISS_REQ;
        else                       w_next = S_IDLE;
      end
      S_MISS_REQ: if (i_mem_req_ack) w_next = S_FILL;
      S_FILL:     if (i_mem_rsp_valid && (r_bypass || r_cnt == OFF_W'(LINE_W-1))) w_next = S_RESP;
      S_WR_REQ:   if (i_mem_req_ack) w_next = r_sc ? S_RESP : S_IDLE;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready     = (r_state == S_IDLE);
    o_rsp_valid     = (r_state == S_RESP);
    o_mem_req_valid = (r_state == S_MISS_REQ) || (r_state == S_WR_REQ);
  end

  assign o_rsp_data     = r_rsp_data;
  assign o_snoop_hit    = r_snoop_hit;
  assign o_mem_req_addr = r_mem_addr;
  assign o_mem_req_rnw  = r_mem_rnw;
  assign o_mem_req_size = r_mem_size;
  assign o_mem_req_be   = r_mem_be;
  assign o_mem_req_data = r_mem_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      r_waddr <= '0; r_load <= 1'b0; r_store <= 1'b0; r_lr <= 1'b0; r_sc <= 1'b0;
      r_be <= '0; r_wdata <= '0; r_cnt <= '0; r_bypass <= 1'b0; r_fill_killed <= 1'b0;
      r_fill_way <= '0; r_repl <= WAYS'(1); r_resv_valid <= 1'b0; r_resv_line <= '0;
      r_rsp_data <= '0; r_snoop_hit <= 1'b0;
      r_mem_addr <= '0; r_mem_data <= '0; r_mem_rnw <= 1'b0; r_mem_size <= '0; r_mem_be <= '0;
    end else begin
      r_repl      <= (r_repl << 1) | (r_repl >> (WAYS-1));
      r_snoop_hit <= |w_sn_vec;
      if (w_accept) begin
        r_waddr <= i_req_addr[31:2];
        r_load  <= i_req_load;  r_store <= i_req_store;
        r_lr    <= i_req_lr;    r_sc    <= i_req_sc;
        r_be    <= i_req_be;    r_wdata <= i_req_wdata;
      end
      if (r_state == S_LOOKUP) begin
        r_cnt         <= '0;
        r_bypass      <= !i_cache_en;
        r_fill_way    <= w_victim;
        r_fill_killed <= w_sn_fill;
        if (r_sc || r_store) begin
          r_mem_addr <= {r_waddr, 2'b00};
          r_mem_rnw  <= 1'b0;
          r_mem_size <= '0;
          r_mem_be   <= r_be;
          r_mem_data <= r_wdata;
          r_rsp_data <= {31'b0, !w_sc_ok};
        end else begin
          r_mem_addr <= i_cache_en ? {w_line, {(OFF_W+2){1'b0}}} : {r_waddr, 2'b00};
          r_mem_rnw  <= 1'b1;
          r_mem_size <= i_cache_en ? 5'(LINE_W-1) : 5'd0;
          r_rsp_data <= w_hit_data;
        end
      end else if (w_sn_fill) begin
        r_fill_killed <= 1'b1;
      end
      if ((r_state == S_FILL) && i_mem_rsp_valid) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_bypass || (r_cnt == w_word)) r_rsp_data <= i_mem_rsp_data;
      end
      // A snoop in the completing cycle still suppresses the valid set.
      for (int w = 0; w < WAYS; w++) begin
        if (w_fill_last && (r_fill_way == WAY_W'(w)) && !(r_fill_killed || w_sn_fill))
          r_valid[w][w_idx] <= 1'b1;
        if (w_sn_vec[w]) r_valid[w][w_sn_idx] <= 1'b0;
      end
      if ((r_state == S_RESP) && r_lr && !w_sn_lr && !i_clear_reservation) begin
        r_resv_valid <= 1'b1;
        r_resv_line  <= w_line;
      end
      if ((r_state == S_LOOKUP) && r_sc) r_resv_valid <= 1'b0;
      if (w_resv_clr) r_resv_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dcache_coherent.sv
// Directed bench for dcache_coherent (WAYS=2, SETS=64, LINE_W=4) with a
// word-addressed backing memory that acknowledges and returns fills.
module tb_dcache_coherent;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cache_en = 1'b1, i_req_valid = 1'b0, o_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_req_load = 1'b0, i_req_store = 1'b0, i_req_lr = 1'b0, i_req_sc = 1'b0;
  logic [3:0]  i_req_be = '0;
  logic [31:0] i_req_wdata = '0;
  logic        i_clear_reservation = 1'b0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_mem_req_valid, i_mem_req_ack = 1'b0;
  logic [31:0] o_mem_req_addr;
  logic        o_mem_req_rnw;
  logic [4:0]  o_mem_req_size;
  logic [3:0]  o_mem_req_be;
  logic [31:0] o_mem_req_data;
  logic        i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_data = '0;
  logic        i_snoop_valid = 1'b0;
  logic [31:0] i_snoop_addr = '0;
  logic        o_snoop_hit;

  dcache_coherent #(.WAYS(2), .SETS(64), .LINE_W(4), .USE_SNOOP(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_cache_en(i_cache_en),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_load(i_req_load), .i_req_store(i_req_store), .i_req_lr(i_req_lr),
    .i_req_sc(i_req_sc), .i_req_be(i_req_be), .i_req_wdata(i_req_wdata),
    .i_clear_reservation(i_clear_reservation),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ack(i_mem_req_ack),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_rnw(o_mem_req_rnw),
    .o_mem_req_size(o_mem_req_size), .o_mem_req_be(o_mem_req_be),
    .o_mem_req_data(o_mem_req_data),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
    .i_snoop_valid(i_snoop_valid), .i_snoop_addr(i_snoop_addr), .o_snoop_hit(o_snoop_hit)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] OP_LD = 4'b1000, OP_ST = 4'b0100, OP_LR = 4'b1010, OP_SC = 4'b0101;

  logic [31:0] mem [16384];
  int          n_chk = 0, n_pass = 0;

  // results of the last access
  logic        t_rsp_seen;
  logic [31:0] t_rsp_data;
  int          t_lat, t_nreq;
  logic [31:0] t_addr, t_data;
  logic [4:0]  t_size;
  logic        t_rnw;
  logic [3:0]  t_be;
  logic        t_snoop_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // One request from issue back to IDLE; the memory side acks and streams
  // words, optionally firing a snoop alongside fill word snoop_word.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int snoop_word, input logic [31:0] sn_addr);
    int   words_left, widx, base;
    logic acked, done;
    t_rsp_seen = 1'b0; t_rsp_data = '0; t_lat = -1; t_nreq = 0;
    words_left = 0; widx = 0; base = 0; acked = 1'b0; done = 1'b0;
    @(negedge clk);
    {i_req_load, i_req_store, i_req_lr, i_req_sc} = op;
    i_req_addr = addr; i_req_be = be; i_req_wdata = wd; i_req_valid = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    for (int k = 1; k < 100 && !done; k++) begin
      if (k > 1) @(negedge clk);
      if (o_rsp_valid) begin t_rsp_seen = 1'b1; t_rsp_data = o_rsp_data; t_lat = k; end
      i_mem_req_ack = 1'b0; i_mem_rsp_valid = 1'b0; i_snoop_valid = 1'b0;
      if (o_req_ready) done = 1'b1;
      else if (o_mem_req_valid && !acked) begin
        acked = 1'b1; t_nreq++;
        t_addr = o_mem_req_addr; t_rnw = o_mem_req_rnw; t_size = o_mem_req_size;
        t_be = o_mem_req_be; t_data = o_mem_req_data;
        i_mem_req_ack = 1'b1;
        base = int'(o_mem_req_addr[15:2]);
        if (o_mem_req_rnw) words_left = int'(o_mem_req_size) + 1;
        else for (int b = 0; b < 4; b++)
          if (o_mem_req_be[b]) mem[base][8*b +: 8] = o_mem_req_data[8*b +: 8];
      end else if (words_left > 0) begin
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = mem[base + widx];
        if (widx == snoop_word) begin i_snoop_valid = 1'b1; i_snoop_addr = sn_addr; end
        widx++; words_left--;
      end
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic snoop(input logic [31:0] addr);
    @(negedge clk);
    i_snoop_valid = 1'b1; i_snoop_addr = addr;
    @(negedge clk);
    i_snoop_valid = 1'b0;
    t_snoop_hit = o_snoop_hit;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 | i;
    mem[16'h40] = 32'hA0; mem[16'h41] = 32'hA1; mem[16'h42] = 32'hA2; mem[16'h43] = 32'hA3;

    // reset
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_mem_req_valid", {31'b0, o_mem_req_valid}, 32'd0);
    check("rst_snoop_hit", {31'b0, o_snoop_hit}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, o_req_ready}, 32'd1);

    // miss fill then hit
    access(OP_LD, 32'h100, 4'h0, 32'h0, -1, 32'h0);
    check("miss_nreq", t_nreq, 1);
    check("miss_addr", t_addr, 32'h100);
    check("miss_size", {27'b0, t_size}, 32'd3);
    check("miss_rnw", {31'b0, t_rnw}, 32'd1);
    check("miss_data", t_rsp_data, 32'hA0);
    access(OP_LD, 32'h104, 4'h0, 32'h0, -1, 32'h0);
    check("hit_nreq", t_nreq, 0);
    check("hit_latency", t_lat, 2);
    check("hit_data", t_rsp_data, 32'hA1);

    // invalid-way-first fill of set 0, then eviction by a third tag
    access(OP_LD, 32'h0000, 4'h0, 32'h0, -1, 32'h0);
    check("set0_a_miss", t_nreq, 1);
    access(OP_LD, 32'h4000, 4'h0, 32'h0, -1, 32'h0);
    check("set0_b_miss", t_nreq, 1);
    check("set0_b_data", t_rsp_data, 32'h5A00_1000);
    access(OP_LD, 32'h0000, 4'h0, 32'h0, -1, 32'h0);
    check("set0_a_hit", t_nreq, 0);
    access(OP_LD, 32'h4000, 4'h0, 32'h0, -1, 32'h0);
    check("set0_b_hit", t_nreq, 0);
    access(OP_LD, 32'h8000, 4'h0, 32'h0, -1, 32'h0);
    check("set0_c_miss", t_nreq, 1);
    check("set0_c_data", t_rsp_data, 32'h5A00_2000);
    begin
      int present;
      snoop(32'h0000); present = int'(t_snoop_hit);
      snoop(32'h4000); present += int'(t_snoop_hit);
      check("evict_exactly_one", present, 1);
      snoop(32'h8000);
      check("set0_c_present", {31'b0, t_snoop_hit}, 32'd1);
    end

    // write-through partial store to a cached word
    access(OP_ST, 32'h104, 4'b0011, 32'hDEADBEEF, -1, 32'h0);
    check("st_nreq", t_nreq, 1);
    check("st_addr", t_addr, 32'h104);
    check("st_size", {27'b0, t_size}, 32'd0);
    check("st_be", {28'b0, t_be}, 32'h3);
    check("st_rnw", {31'b0, t_rnw}, 32'd0);
    check("st_data", t_data, 32'hDEADBEEF);
    check("st_no_rsp", {31'b0, t_rsp_seen}, 32'd0);
    access(OP_LD, 32'h104, 4'h0, 32'h0, -1, 32'h0);
    check("st_reload_nreq", t_nreq, 0);
    check("st_reload_data", t_rsp_data, 32'h0000BEEF);

    // bypass read with the cache disabled
    i_cache_en = 1'b0;
    access(OP_LD, 32'h104, 4'h0, 32'h0, -1, 32'h0);
    i_cache_en = 1'b1;
    check("byp_size", {27'b0, t_size}, 32'd0);
    check("byp_addr", t_addr, 32'h104);
    check("byp_data", t_rsp_data, 32'h0000BEEF);

    // LR / SC
    access(OP_LR, 32'h200, 4'h0, 32'h0, -1, 32'h0);
    check("lr_data", t_rsp_data, 32'h5A00_0080);
    access(OP_SC, 32'h204, 4'hF, 32'h12345678, -1, 32'h0);
    check("sc1_nreq", t_nreq, 1);
    check("sc1_addr", t_addr, 32'h204);
    check("sc1_rsp", {31'b0, t_rsp_seen}, 32'd1);
    check("sc1_data", t_rsp_data, 32'd0);
    access(OP_SC, 32'h204, 4'hF, 32'h12345678, -1, 32'h0);
    check("sc2_nreq", t_nreq, 0);
    check("sc2_data", t_rsp_data, 32'd1);

    // snoop kills both the line and the reservation
    access(OP_LR, 32'h200, 4'h0, 32'h0, -1, 32'h0);
    check("lr2_hit", t_nreq, 0);
    snoop(32'h20C);
    check("snoop_hit", {31'b0, t_snoop_hit}, 32'd1);
    access(OP_SC, 32'h200, 4'hF, 32'h0, -1, 32'h0);
    check("sc3_nreq", t_nreq, 0);
    check("sc3_data", t_rsp_data, 32'd1);
    access(OP_LD, 32'h200, 4'h0, 32'h0, -1, 32'h0);
    check("snooped_miss", t_nreq, 1);
    check("snooped_data", t_rsp_data, 32'h5A00_0080);

    // snoop during fill: data returned, line left invalid
    access(OP_LD, 32'h300, 4'h0, 32'h0, 1, 32'h300);
    check("kill_nreq", t_nreq, 1);
    check("kill_data", t_rsp_data, 32'h5A00_00C0);
    access(OP_LD, 32'h300, 4'h0, 32'h0, -1, 32'h0);
    check("kill_refill", t_nreq, 1);
    check("kill_refill_data", t_rsp_data, 32'h5A00_00C0);
    access(OP_LD, 32'h308, 4'h0, 32'h0, -1, 32'h0);
    check("refill_hit", t_nreq, 0);
    check("refill_hit_data", t_rsp_data, 32'h5A00_00C2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dcache_coherent.md
Name: dcache_coherent

Overview:
- Parametrised successor to the core's blocking L1 data cache: N-way set-associative, write-through, read-allocate.
- Adds three things: a snoop-invalidation port for the peer core in the dual-core system, invalid-way-first replacement, and line-granular LR/SC reservation tracking.
- Sits between the load/store unit and the L1 arbiter; it is the only path from a core to shared memory.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 64, sets per way; power of two.
- LINE_W, 4, 32-bit words per line; power of two, 2..16.
- USE_SNOOP, 1, when 0 snoop_valid is ignored and the snoop logic is removed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cache_en  in  1  cache enable; when 0 all accesses bypass the arrays
- req_valid  in  1  LSU request
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  byte address
- req_load / req_store  in  1 / 1  operation type
- req_lr / req_sc  in  1 / 1  load-reserved / store-conditional qualifiers
- req_be  in  4  store byte enables
- req_wdata  in  32  store data
- clear_reservation  in  1  exception-driven reservation clear
- rsp_valid  out  1  load/LR/SC result valid, one-cycle pulse
- rsp_data  out  32  load data, or SC result (0 = success, 1 = fail)
- mem_req_valid  out  1  arbiter request, held until mem_req_ack
- mem_req_ack  in  1  arbiter accept
- mem_req_addr  out  32  word-aligned address; line-aligned for fills
- mem_req_rnw  out  1  1 = read
- mem_req_size  out  5  burst length minus 1
- mem_req_be / mem_req_data  out  4 / 32  write byte enables / write data
- mem_rsp_valid / mem_rsp_data  in  1 / 32  returned read word, in ascending address order
- snoop_valid / snoop_addr  in  1 / 32  invalidate request from the peer core
- snoop_hit  out  1  registered; a snoop invalidated at least one way

Behaviour:
- Reset values (asynchronous on rst_n low):
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, mem_req_valid=0, snoop_hit=0.
  - Internal: all valid bits 0, reservation invalid, FSM in IDLE, replacement pointer one-hot way 0.
- Address split: offset [1:0], word [log2 LINE_W+1:2], index of log2 SETS bits, remaining bits are the tag.
- Array structure:
  - Tag and data arrays are synchronous-read, read in the accept cycle.
  - Valid bits are flops, read combinationally in LOOKUP.
- FSM states: IDLE, LOOKUP, MISS_REQ, FILL, WR_REQ, RESP. req_ready=1 only in IDLE.
- IDLE: on accept, register the request and go to LOOKUP.
- LOOKUP:
  - hit = cache_en & |(valid & tag match).
  - Load/LR hit: rsp_valid and hit data in the next cycle, then IDLE. Accept at T gives response at T+2.
  - Load/LR miss with cache_en=1: go to MISS_REQ with size LINE_W-1.
  - Load with cache_en=0: single-word read, size 0, no allocation.
  - Store: on a hit, write the data array byte-wise with req_be. Go to WR_REQ (write-through, no allocate on miss).
  - SC: if the reservation is valid and its line address matches, go to WR_REQ. Otherwise go to RESP with rsp_data=1 and no memory access.
  - Every SC clears the reservation.
- Fill way: lowest-numbered invalid way in the set if one exists, else the replacement pointer (a one-hot rotator advancing every cycle). The way is latched in LOOKUP.
- MISS_REQ / WR_REQ: hold mem_req_valid and all request fields stable until mem_req_ack.
  - After ack, MISS_REQ goes to FILL.
  - After ack, a store returns to IDLE with no rsp_valid.
  - After ack, a successful SC goes to RESP with rsp_data=0.
- FILL:
  - A word counter increments on each mem_rsp_valid and writes the data array at the latched way.
  - The word at the request's word offset is captured for the response.
  - On the last word (count == LINE_W-1): write tag, set valid unless fill_killed, go to RESP.
  - Bypass reads complete after 1 word with no array writes.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- LR: on response it also sets the reservation to the line address.
- Snoop (USE_SNOOP=1):
  - In the cycle snoop_valid is high, clear the valid bit of every way in the snoop index whose tag matches. snoop_hit=1 in the next cycle.
  - The cleared valid bit is visible to a LOOKUP one cycle later.
  - A matching line address clears the reservation.
  - A snoop matching the line being filled sets fill_killed: the fill completes and data is returned, but the valid bit is not set.
- Simultaneous events:
  - Snoop and fill-complete valid-set on the same set and way: the invalidate wins.
  - Snoop and LR reservation-set on the same line in the same cycle: the reservation stays invalid.
  - clear_reservation has equal priority to a snoop clear.
- cache_en is sampled in LOOKUP only. Changing it mid-fill does not abort the fill.

Test Plan:
- Reset, then load 0x100 → MISS_REQ at addr 0x100, size 3. Return words 0xA0..0xA3 → rsp_data=0xA0. A repeat load of 0x104 hits: rsp_valid 2 cycles after accept, data 0xA1.
- Fill set 0 with ways 0 and 1 via loads 0x0000 and 0x4000 (SETS=64, LINE_W=4) → invalid-way-first replacement. A third tag 0x8000 evicts the rotator way; the previous two tags are checked for exactly one miss.
- Store 0xDEADBEEF, be=4'b0011, to a cached 0x104 → one write, size 0, be 0x3. A following load of 0x104 returns 0xA1 with bytes [1:0] = 0xBEEF.
- LR 0x200 then SC 0x204 → mem write issued, rsp_data=0. A second SC → rsp_data=1 with no mem_req_valid.
- LR 0x200, snoop 0x20C, SC 0x200 → snoop_hit=1, the SC fails with rsp_data=1, and a load of 0x200 misses.
- Snoop 0x300 during the fill of line 0x300 → load data returned correctly; an immediate reload of 0x300 misses and re-fills.
